// File: rtl/ram_pkg.sv
// Shared constants and types for the 7x17 register RAM controller.
package ram_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 17;
  localparam int DEPTH  = 7;

  localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 3'd7;
  localparam logic [ADDR_W-1:0] LAST_IDX     = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;
  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_e;

  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(DEPTH);
  endfunction

endpackage

// File: rtl/ram_7x17_ctrl_if.sv
// Write-request, read-forwarding and RAM-side signals of the 7x17 RAM controller.
interface ram_7x17_ctrl_if;
  import ram_pkg::*;

  logic              a_valid, a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid, b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic [ADDR_W-1:0] ra1, ra2;
  logic [DATA_W-1:0] ram_rd1, ram_rd2;
  logic [ADDR_W-1:0] ram_wr;
  logic [DATA_W-1:0] ram_wrd;
  logic              ram_we;
  logic [DATA_W-1:0] rd1, rd2;
  logic              init_done;
  logic              err_addr;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, ra1, ra2, ram_rd1, ram_rd2,
    input  a_ready, b_ready, ram_wr, ram_wrd, ram_we, rd1, rd2, init_done, err_addr
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, ra1, ra2, ram_rd1, ram_rd2,
    output a_ready, b_ready, ram_wr, ram_wrd, ram_we, rd1, rd2, init_done, err_addr
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with zero-latency grant; pointer flips to the loser after a grant.
module rr_arb2
  import ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  req_id_e ptr_q, ptr_d;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    gnt_o = req_i;
    ptr_d = ptr_q;
    if (req_i == 2'b11) gnt_o = (ptr_q == REQ_A) ? 2'b01 : 2'b10;
    if (gnt_o[0])      ptr_d = REQ_B;
    else if (gnt_o[1]) ptr_d = REQ_A;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= REQ_A;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ram_7x17_ctrl.sv
// Clears the 7x17 RAM after reset, then arbitrates its write port between A and B and forwards writes to reads.
module ram_7x17_ctrl
  import ram_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  ram_7x17_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr;
  logic [DATA_W-1:0] wr_data_q, wr_data;
  logic              err_q, err_d;
  logic              we;
  logic [1:0]        req, gnt;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;

  // Requests are masked while clearing or in reset, so ready can never rise then.
  assign req = (state_q == ST_RUN && rst_n) ? {bus.b_valid, bus.a_valid} : 2'b00;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req),
    .gnt_o (gnt)
  );

  assign gnt_addr = gnt[1] ? bus.b_addr : bus.a_addr;
  assign gnt_data = gnt[1] ? bus.b_data : bus.a_data;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we      = 1'b0;
    wr_addr = wr_addr_q;
    wr_data = wr_data_q;
    err_d   = 1'b0;
    case (state_q)
      ST_INIT: begin
        we      = 1'b1;
        wr_addr = idx_q;
        wr_data = '0;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        if (|gnt) begin
          if (addr_legal(gnt_addr)) begin
            we      = 1'b1;
            wr_addr = gnt_addr;
            wr_data = gnt_data;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    endcase
    // The write strobe must drop the instant reset asserts, not at the next edge.
    if (!rst_n) we = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      idx_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_addr_q <= wr_addr;
      wr_data_q <= wr_data;
      err_q     <= err_d;
    end
  end

  assign bus.a_ready   = gnt[0];
  assign bus.b_ready   = gnt[1];
  assign bus.ram_we    = we;
  assign bus.ram_wr    = wr_addr;
  assign bus.ram_wrd   = wr_data;
  assign bus.init_done = (state_q == ST_RUN);
  assign bus.err_addr  = err_q;
  assign bus.rd1       = (we && wr_addr == bus.ra1) ? wr_data : bus.ram_rd1;
  assign bus.rd2       = (we && wr_addr == bus.ra2) ? wr_data : bus.ram_rd2;

endmodule

// File: tb/tb_ram_7x17_ctrl.sv
// Self-checking bench for ram_7x17_ctrl: RAM model, expected-write scoreboard, per-feature scenario tasks.
module tb_ram_7x17_ctrl;
  import ram_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_7x17_ctrl_if bus ();

  ram_7x17_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int      checks = 0;
  int      errors = 0;
  wr_t     exp_q[$];
  wr_t     mon_exp;
  req_id_e exp_ptr = REQ_A;

  // RAM model starts with non-zero contents so the clear sequence is observable.
  logic [DATA_W-1:0] mem [DEPTH] = '{17'h1abcd, 17'h0f00f, 17'h12345, 17'h1dead,
                                     17'h0beef, 17'h1c0de, 17'h0cafe};

  always @(posedge clk)
    if (bus.ram_we && int'(bus.ram_wr) < DEPTH) mem[bus.ram_wr] <= bus.ram_wrd;

  assign bus.ram_rd1 = (int'(bus.ra1) < DEPTH) ? mem[bus.ra1] : '0;
  assign bus.ram_rd2 = (int'(bus.ra2) < DEPTH) ? mem[bus.ra2] : '0;

  // Scoreboard: every observed RAM write must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.ram_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %0h, none expected", bus.ram_wr, bus.ram_wrd);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bus.ram_wr, bus.ram_wrd} !== mon_exp) begin
          errors++;
          $display("FAIL ram_write: got addr %0d data %0h, expected addr %0d data %0h",
                   bus.ram_wr, bus.ram_wrd, mon_exp.addr, mon_exp.data);
        end
      end
    end
  end

  // Drives one cycle of requests and predicts grants from the round-robin model.
  task automatic step(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                      input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd,
                      output logic ga, output logic gb, output logic ill);
    @(posedge clk); #1;
    bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
    bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
    ga  = av && (!bv || exp_ptr == REQ_A);
    gb  = bv && !ga;
    ill = 1'b0;
    if (ga) begin
      exp_ptr = REQ_B;
      if (int'(aa) < DEPTH) exp_q.push_back('{aa, ad}); else ill = 1'b1;
    end else if (gb) begin
      exp_ptr = REQ_A;
      if (int'(ba) < DEPTH) exp_q.push_back('{ba, bd}); else ill = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic run_init();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back('{ADDR_W'(i), {DATA_W{1'b0}}});
    bus.a_valid = 1'b1; bus.b_valid = 1'b1; bus.ra1 = 3'd3;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.a_ready, bus.b_ready} !== 2'b00) begin
        errors++; $display("FAIL init_ready: cycle %0d got %b expected 00", i, {bus.a_ready, bus.b_ready});
      end
      checks++;
      if (bus.init_done !== 1'b0 || bus.ram_we !== 1'b1) begin
        errors++; $display("FAIL init_state: cycle %0d got done=%b we=%b expected done=0 we=1", i, bus.init_done, bus.ram_we);
      end
      if (i == 3) begin
        checks++;
        if (bus.rd1 !== '0) begin
          errors++; $display("FAIL init_forward: got rd1 %0h expected 0", bus.rd1);
        end
      end
      if (i == DEPTH - 1) begin
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.init_done !== 1'b1 || bus.ram_we !== 1'b0) begin
      errors++; $display("FAIL init_end: got done=%b we=%b expected done=1 we=0", bus.init_done, bus.ram_we);
    end
    exp_ptr = REQ_A;
  endtask

  task automatic test_reset();
    bus.a_valid = 1'b1; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b1; bus.b_addr = '0; bus.b_data = '0;
    bus.ra1 = '0; bus.ra2 = '0;
    #1;
    checks++;
    if ({bus.ram_we, bus.a_ready, bus.b_ready, bus.init_done, bus.err_addr} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got we/ar/br/done/err %b expected 00000",
                         {bus.ram_we, bus.a_ready, bus.b_ready, bus.init_done, bus.err_addr});
    end
    repeat (2) @(posedge clk);
    run_init();
  endtask

  task automatic test_back_to_back();
    logic ga, gb, ill;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 3'd1, DATA_W'(100 + i), 1'b1, 3'd3, DATA_W'(200 + i), ga, gb, ill);
      checks++;
      if (bus.a_ready !== ga || bus.b_ready !== gb || ga !== (i % 2 == 0)) begin
        errors++; $display("FAIL rr_grant: cycle %0d got a=%b b=%b expected a=%b b=%b",
                           i, bus.a_ready, bus.b_ready, ga, gb);
      end
    end
  endtask

  task automatic test_single_write();
    logic ga, gb, ill;
    step(1'b1, 3'd2, 17'd25, 1'b0, 3'd0, 17'd0, ga, gb, ill);
    checks++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0 || bus.ram_we !== 1'b1 || bus.ram_wr !== 3'd2) begin
      errors++; $display("FAIL single_a: got ar=%b br=%b we=%b wr=%0d expected 1 0 1 2",
                         bus.a_ready, bus.b_ready, bus.ram_we, bus.ram_wr);
    end
    bus.ra1 = 3'd2;
    step(1'b0, 3'd0, 17'd0, 1'b0, 3'd0, 17'd0, ga, gb, ill);
    checks++;
    if (bus.rd1 !== 17'd25 || bus.ram_we !== 1'b0 || bus.a_ready !== 1'b0) begin
      errors++; $display("FAIL readback: got rd1=%0d we=%b ar=%b expected 25 0 0", bus.rd1, bus.ram_we, bus.a_ready);
    end
  endtask

  task automatic test_illegal_addr();
    logic ga, gb, ill;
    step(1'b0, 3'd0, 17'd0, 1'b1, ADDR_ILLEGAL, 17'd5, ga, gb, ill);
    checks++;
    if (bus.b_ready !== 1'b1 || bus.ram_we !== 1'b0 || bus.err_addr !== 1'b0 || !ill) begin
      errors++; $display("FAIL illegal_accept: got br=%b we=%b err=%b expected 1 0 0", bus.b_ready, bus.ram_we, bus.err_addr);
    end
    step(1'b0, 3'd0, 17'd0, 1'b0, 3'd0, 17'd0, ga, gb, ill);
    checks++;
    if (bus.err_addr !== 1'b1) begin
      errors++; $display("FAIL err_pulse: got %b expected 1", bus.err_addr);
    end
    step(1'b1, 3'd5, 17'd9, 1'b1, 3'd6, 17'd11, ga, gb, ill);
    checks++;
    if (bus.err_addr !== 1'b0) begin
      errors++; $display("FAIL err_clear: got %b expected 0", bus.err_addr);
    end
    checks++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0 || ga !== 1'b1) begin
      errors++; $display("FAIL ptr_after_illegal: got a=%b b=%b expected a=1 b=0", bus.a_ready, bus.b_ready);
    end
  endtask

  task automatic test_forward();
    logic ga, gb, ill;
    bus.ra2 = 3'd4;
    bus.ra1 = 3'd5;
    step(1'b1, 3'd4, 17'd78, 1'b0, 3'd0, 17'd0, ga, gb, ill);
    checks++;
    if (bus.rd2 !== 17'd78) begin
      errors++; $display("FAIL forward_rd2: got %0d expected 78", bus.rd2);
    end
    checks++;
    if (bus.rd1 !== 17'd9) begin
      errors++; $display("FAIL no_forward_rd1: got %0d expected 9", bus.rd1);
    end
    step(1'b0, 3'd0, 17'd0, 1'b0, 3'd0, 17'd0, ga, gb, ill);
    checks++;
    if (bus.rd2 !== 17'd78 || bus.ram_we !== 1'b0) begin
      errors++; $display("FAIL ram_rd2: got rd2=%0d we=%b expected 78 0", bus.rd2, bus.ram_we);
    end
    checks++;
    if (bus.ram_wr !== 3'd4 || bus.ram_wrd !== 17'd78) begin
      errors++; $display("FAIL wr_hold: got addr %0d data %0d expected 4 78", bus.ram_wr, bus.ram_wrd);
    end
  endtask

  task automatic test_reset_mid();
    logic ga, gb, ill;
    step(1'b1, 3'd5, 17'd1, 1'b1, 3'd6, 17'd2, ga, gb, ill);
    checks++;
    if ((bus.a_ready ^ bus.b_ready) !== 1'b1 || bus.ram_we !== 1'b1) begin
      errors++; $display("FAIL pre_reset_grant: got a=%b b=%b we=%b expected one grant, we=1",
                         bus.a_ready, bus.b_ready, bus.ram_we);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.a_ready, bus.b_ready, bus.ram_we, bus.init_done} !== 4'b0) begin
      errors++; $display("FAIL mid_reset_drop: got ar/br/we/done %b expected 0000",
                         {bus.a_ready, bus.b_ready, bus.ram_we, bus.init_done});
    end
    run_init();
    step(1'b1, 3'd0, 17'd7, 1'b1, 3'd1, 17'd8, ga, gb, ill);
    checks++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
      errors++; $display("FAIL ptr_after_reset: got a=%b b=%b expected a=1 b=0", bus.a_ready, bus.b_ready);
    end
  endtask

  initial begin
    logic ga, gb, ill;
    test_reset();
    test_back_to_back();
    test_single_write();
    test_illegal_addr();
    test_forward();
    test_reset_mid();
    step(1'b0, 3'd0, 17'd0, 1'b0, 3'd0, 17'd0, ga, gb, ill);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL pending_writes: got %0d outstanding expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
